inv_sbox_layer: RTL and testbench

INV_SBOX_LAYER -- requirements
Module: inv_sbox_layer

---
 rtl/inv_sbox_layer_pkg.sv | 26 ++
 rtl/inv_sbox_layer_nibble.sv | 11 +
 rtl/inv_sbox_layer.sv | 100 ++++++++++
 tb/tb_inv_sbox_layer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inv_sbox_layer_pkg.sv
// rtl/inv_sbox_layer_pkg.sv - shared constants, FSM encoding and inverse S-box table
package inv_sbox_layer_pkg;

  localparam int STATE_W = 128;
  localparam int ROW_W   = 32;
  localparam int NROWS   = 4;
  localparam int NIB_W   = 4;
  localparam int COL_W   = $clog2(ROW_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Entry i is the inverse image of nibble i; entry 15 sits at the MSB end.
  localparam logic [15:0][NIB_W-1:0] INV_SBOX = {
    4'h3, 4'hc, 4'h9, 4'hf, 4'he, 4'h5, 4'h7, 4'h1,
    4'h6, 4'hb, 4'ha, 4'h8, 4'hd, 4'h4, 4'h2, 4'h0
  };

  function automatic logic [NIB_W-1:0] inv_sb(input logic [NIB_W-1:0] x);
    return INV_SBOX[x];
  endfunction

endpackage

// File: rtl/inv_sbox_layer_nibble.sv
// rtl/inv_sbox_layer_nibble.sv - combinational 4-bit inverse S-box
module inv_sb_nibble
  import inv_sbox_layer_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  output logic [NIB_W-1:0] y
);

  assign y = inv_sb(x);

endmodule

// File: rtl/inv_sbox_layer.sv
// rtl/inv_sbox_layer.sv - column-serial inverse S-box layer over a 128-bit Clyde state
module inv_sbox_layer
  import inv_sbox_layer_pkg::*;
#(
  parameter int NPAR = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state
);

  localparam int NGRP  = ROW_W / NPAR;
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

  state_t                        state, state_nxt;
  logic [CNT_W-1:0]              cnt;
  logic [NROWS-1:0][ROW_W-1:0]   work;
  logic [NROWS-1:0][ROW_W-1:0]   work_sub;
  logic [COL_W-1:0]              base;
  logic [NPAR-1:0][NIB_W-1:0]    nib_in;
  logic [NPAR-1:0][NIB_W-1:0]    nib_out;
  logic                          last_grp;

  assign last_grp = (cnt == CNT_LAST);
  assign base     = COL_W'(32'(cnt) * NPAR);

  // Gather one column per lane: nibble bit k comes from row k.
  for (genvar g = 0; g < NPAR; g++) begin : g_lane
    logic [COL_W-1:0] col;
    assign col       = base + COL_W'(g);
    assign nib_in[g] = {work[3][col], work[2][col], work[1][col], work[0][col]};

    inv_sb_nibble u_sb (
      .x (nib_in[g]),
      .y (nib_out[g])
    );
  end

  // Scatter back: only the columns of the active group are replaced.
  for (genvar j = 0; j < ROW_W; j++) begin : g_col
    localparam int GRP  = j / NPAR;
    localparam int LANE = j % NPAR;
    for (genvar k = 0; k < NROWS; k++) begin : g_row
      assign work_sub[k][j] = (cnt == CNT_W'(GRP)) ? nib_out[LANE][k] : work[k][j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last_grp)  state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      work <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_state;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work <= work_sub;
          cnt  <= last_grp ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_state = work;

endmodule

// File: tb/tb_inv_sbox_layer.sv
// tb/tb_inv_sbox_layer.sv - scoreboard bench over NPAR = 1, 4 and 32 instances
module tb_inv_sbox_layer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_state = '0;
  logic [2:0]   ir;
  logic [2:0]   ov;
  logic [127:0] os [3];

  int errors = 0;
  int checks = 0;

  logic [127:0] q0[$];
  logic [127:0] q1[$];
  logic [127:0] q2[$];

  always #5 clk = ~clk;

  inv_sbox_layer #(.NPAR(1)) u_p1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .in_state(in_state),
    .out_valid(ov[0]), .out_ready(out_ready), .out_state(os[0])
  );
  inv_sbox_layer #(.NPAR(4)) u_p4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .in_state(in_state),
    .out_valid(ov[1]), .out_ready(out_ready), .out_state(os[1])
  );
  inv_sbox_layer #(.NPAR(32)) u_p32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .in_state(in_state),
    .out_valid(ov[2]), .out_ready(out_ready), .out_state(os[2])
  );

  function automatic int npar_of(input int i);
    case (i)
      0:       return 1;
      1:       return 4;
      default: return 32;
    endcase
  endfunction

  function automatic logic [3:0] ref_sb(input logic [3:0] x);
    case (x)
      4'h0: return 4'h0;  4'h1: return 4'h2;  4'h2: return 4'h4;  4'h3: return 4'hd;
      4'h4: return 4'h8;  4'h5: return 4'ha;  4'h6: return 4'hb;  4'h7: return 4'h6;
      4'h8: return 4'h1;  4'h9: return 4'h7;  4'ha: return 4'h5;  4'hb: return 4'he;
      4'hc: return 4'hf;  4'hd: return 4'h9;  4'he: return 4'hc;  default: return 4'h3;
    endcase
  endfunction

  function automatic logic [127:0] ref_inv(input logic [127:0] s);
    logic [127:0] r;
    logic [3:0]   n, m;
    r = '0;
    for (int j = 0; j < 32; j++) begin
      n = {s[96+j], s[64+j], s[32+j], s[j]};
      m = ref_sb(n);
      r[j] = m[0]; r[32+j] = m[1]; r[64+j] = m[2]; r[96+j] = m[3];
    end
    return r;
  endfunction

  task automatic push_exp(input logic [127:0] v);
    q0.push_back(v); q1.push_back(v); q2.push_back(v);
  endtask

  task automatic pop_exp(input int i, output logic [127:0] v, output bit ok);
    ok = 1'b1; v = '0;
    case (i)
      0: if (q0.size() > 0) v = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) v = q1.pop_front(); else ok = 1'b0;
      default: if (q2.size() > 0) v = q2.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic transact(input logic [127:0] st, input int hold, input string name);
    int lat [3];
    logic [127:0] want [3];
    bit stable [3];
    bit ok;
    lat = '{0, 0, 0};
    in_state = st;
    in_valid = 1'b1;
    push_exp(ref_inv(st));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_state = ~st;
    for (int c = 1; c <= 100; c++) begin
      for (int i = 0; i < 3; i++) if (lat[i] == 0 && ov[i]) lat[i] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (lat[i] !== 32 / npar_of(i) + 1) begin
        errors++;
        $display("FAIL %s latency npar=%0d: got %0d want %0d", name, npar_of(i), lat[i], 32 / npar_of(i) + 1);
      end
      pop_exp(i, want[i], ok);
      checks++;
      if (!ok || os[i] !== want[i]) begin
        errors++;
        $display("FAIL %s data npar=%0d: got %h want %h", name, npar_of(i), os[i], want[i]);
      end
      checks++;
      if (ir[i] !== 1'b0) begin
        errors++;
        $display("FAIL %s in_ready_done npar=%0d: got %b want 0", name, npar_of(i), ir[i]);
      end
      stable[i] = 1'b1;
    end
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
          if (ov[i] !== 1'b1 || ir[i] !== 1'b0 || os[i] !== want[i]) stable[i] = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (!stable[i]) begin
          errors++;
          $display("FAIL %s stall npar=%0d: got unstable (ov=%b ir=%b) want held", name, npar_of(i), ov[i], ir[i]);
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ov[i] !== 1'b0 || ir[i] !== 1'b1) begin
        errors++;
        $display("FAIL %s handoff npar=%0d: got ov=%b ir=%b want ov=0 ir=1", name, npar_of(i), ov[i], ir[i]);
      end
    end
  endtask

  task automatic check_reset_vals(input string name);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ir[i] !== 1'b1 || ov[i] !== 1'b0 || os[i] !== 128'h0) begin
        errors++;
        $display("FAIL %s npar=%0d: got ir=%b ov=%b os=%h want ir=1 ov=0 os=0", name, npar_of(i), ir[i], ov[i], os[i]);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    check_reset_vals("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [127:0] want;
    transact(128'h0, 0, "zero");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (os[i] !== 128'h0) begin
        errors++;
        $display("FAIL zero_const npar=%0d: got %h want 0", npar_of(i), os[i]);
      end
    end
    transact(128'h00000000_00000000_00000000_FFFFFFFF, 0, "nib1");
    want = 128'h00000000_00000000_FFFFFFFF_00000000;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (os[i] !== want) begin
        errors++;
        $display("FAIL nib1_const npar=%0d: got %h want %h", npar_of(i), os[i], want);
      end
    end
    transact({128{1'b1}}, 0, "nibf");
    want = 128'h00000000_00000000_FFFFFFFF_FFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (os[i] !== want) begin
        errors++;
        $display("FAIL nibf_const npar=%0d: got %h want %h", npar_of(i), os[i], want);
      end
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 8; n++)
      transact({$urandom, $urandom, $urandom, $urandom}, 0, "random");
  endtask

  task automatic test_stall;
    transact({$urandom, $urandom, $urandom, $urandom}, 20, "stall");
  endtask

  task automatic test_back_to_back;
    logic [127:0] st, want;
    int first [3];
    int second [3];
    bit data_ok [3];
    st = {$urandom, $urandom, $urandom, $urandom};
    want = ref_inv(st);
    first = '{-1, -1, -1};
    second = '{-1, -1, -1};
    data_ok = '{1'b1, 1'b1, 1'b1};
    in_state = st;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (os[i] !== want) data_ok[i] = 1'b0;
          if (first[i] < 0) first[i] = c;
          else if (second[i] < 0) second[i] = c;
        end
      end
    end
    in_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (first[i] < 0 || second[i] < 0 || second[i] - first[i] !== 32 / npar_of(i) + 2) begin
        errors++;
        $display("FAIL b2b_period npar=%0d: got %0d want %0d", npar_of(i), second[i] - first[i], 32 / npar_of(i) + 2);
      end
      checks++;
      if (!data_ok[i]) begin
        errors++;
        $display("FAIL b2b_data npar=%0d: got wrong output want %h", npar_of(i), want);
      end
    end
  endtask

  task automatic test_reset_mid_busy;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_busy");
    #1;
    rst_n = 1'b1;
    transact({$urandom, $urandom, $urandom, $urandom}, 0, "after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
